// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment table entries are full CA bytes with the decimal point off.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index 15 (F) first, index 0 last.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/sseg_decode.sv
// Combinational hex nibble + decimal point to active-low cathode byte.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] ca
);

  assign ca = {~dp, SEG_TABLE[nibble][6:0]};

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode display; frames are swapped only at
// frame boundaries, every slot opens with a blanking gap, all outputs are registered.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*N_DIGITS-1:0] DIGITS_IN,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic [N_DIGITS-1:0]   EN_IN,
  input  logic                  LOAD_REQ,
  output logic                  LOAD_ACK,
  output logic [7:0]            SSEG_CA,
  output logic [N_DIGITS-1:0]   SSEG_AN,
  output logic                  FRAME_START
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0]   dp_q, en_q;

  logic                  above_found;
  logic [IW-1:0]         above_idx, low_sh, low_in;
  logic                  slot_end, boundary, load, fs_d;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic [7:0]            dec_ca, ca_d;
  logic [N_DIGITS-1:0]   an_d;

  // Descending scans leave the lowest matching index behind.
  always_comb begin
    above_found = 1'b0;
    above_idx   = '0;
    low_sh      = '0;
    low_in      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (en_q[i]) low_sh = IW'(i);
      if (EN_IN[i]) low_in = IW'(i);
      if (en_q[i] && (IW'(i) > idx_q)) begin
        above_found = 1'b1;
        above_idx   = IW'(i);
      end
    end
  end

  assign slot_end = (state_q != IDLE) && (cnt_q == CW'(TICK_DIV - 1));
  assign boundary = slot_end && !above_found;
  assign load     = LOAD_REQ && ((state_q == IDLE) || boundary);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (EN_IN == '0) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        state_d = BLANK;
        idx_d   = low_in;
        fs_d    = 1'b1;
      end
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (slot_end) begin
      // No load at a boundary: the current frame simply repeats.
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = above_found ? above_idx : low_sh;
      fs_d    = boundary;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(BLANK_CYC)) state_d = DRIVE;
    end
  end

  // Shadow contents cannot change while entering DRIVE, so the registered copy is current.
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == idx_d) begin
        nib    = dig_q[4*i +: 4];
        dp_sel = dp_q[i];
      end
    end
  end

  sseg_decode u_decode (
    .nibble (nib),
    .dp     (dp_sel),
    .ca     (dec_ca)
  );

  always_comb begin
    an_d = '1;
    ca_d = SEG_BLANK;
    if (state_d == DRIVE) begin
      an_d[idx_d] = 1'b0;
      ca_d        = dec_ca;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      dig_q       <= '0;
      dp_q        <= '0;
      en_q        <= '0;
      LOAD_ACK    <= 1'b0;
      FRAME_START <= 1'b0;
      SSEG_AN     <= '1;
      SSEG_CA     <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      LOAD_ACK    <= load;
      FRAME_START <= fs_d;
      SSEG_AN     <= an_d;
      SSEG_CA     <= ca_d;
      if (load) begin
        dig_q <= DIGITS_IN;
        dp_q  <= DP_IN;
        en_q  <= EN_IN;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (TICK_DIV=10, BLANK_CYC=2) with an expected-output queue.
module tb_sseg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] DIGITS_IN;
  logic [7:0]  DP_IN;
  logic [7:0]  EN_IN;
  logic        LOAD_REQ;
  logic        LOAD_ACK;
  logic [7:0]  SSEG_CA;
  logic [7:0]  SSEG_AN;
  logic        FRAME_START;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] ca;
    logic       ack;
    logic       fs;
    string      tag;
  } exp_t;

  exp_t q[$];

  logic [7:0] tb_seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  localparam logic [31:0] DIG_A  = 32'h76543210;
  localparam logic [31:0] DIG_B  = 32'hFEDCBA98;
  localparam logic [31:0] DIG_SP = 32'h8000000A;
  localparam logic [31:0] DIG_F  = 32'h0000000F;

  sseg_scan_ctrl #(
    .N_DIGITS  (8),
    .TICK_DIV  (10),
    .BLANK_CYC (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .DIGITS_IN   (DIGITS_IN),
    .DP_IN       (DP_IN),
    .EN_IN       (EN_IN),
    .LOAD_REQ    (LOAD_REQ),
    .LOAD_ACK    (LOAD_ACK),
    .SSEG_CA     (SSEG_CA),
    .SSEG_AN     (SSEG_AN),
    .FRAME_START (FRAME_START)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] seg(input logic [3:0] n, input logic dp);
    logic [7:0] t;
    t = tb_seg[n];
    return {~dp, t[6:0]};
  endfunction

  task automatic push(input logic [7:0] an, input logic [7:0] ca, input logic ack,
                      input logic fs, input string tag);
    exp_t e;
    e.an = an; e.ca = ca; e.ack = ack; e.fs = fs; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) push(8'hFF, 8'hFF, 1'b0, 1'b0, tag);
  endtask

  // One full slot: two blank cycles, then eight driven cycles.
  task automatic push_slot(input int idx, input logic [31:0] dig, input logic [7:0] dp,
                           input logic ack, input logic fs, input string tag);
    logic [7:0] an;
    an      = 8'hFF;
    an[idx] = 1'b0;
    push(8'hFF, 8'hFF, ack, fs, tag);
    push(8'hFF, 8'hFF, 1'b0, 1'b0, tag);
    repeat (8) push(an, seg(dig[4*idx +: 4], dp[idx]), 1'b0, 1'b0, tag);
  endtask

  task automatic drive(input logic [31:0] dig, input logic [7:0] dp, input logic [7:0] en);
    DIGITS_IN = dig;
    DP_IN     = dp;
    EN_IN     = en;
    LOAD_REQ  = 1'b1;
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (q.size() == 0) begin
        miscompares++;
        $error("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        e = q.pop_front();
        vectors++;
        assert (SSEG_AN === e.an) else begin
          miscompares++;
          $error("FAIL %s AN observed %h expected %h", e.tag, SSEG_AN, e.an);
        end
        vectors++;
        assert (SSEG_CA === e.ca) else begin
          miscompares++;
          $error("FAIL %s CA observed %h expected %h", e.tag, SSEG_CA, e.ca);
        end
        vectors++;
        assert (LOAD_ACK === e.ack) else begin
          miscompares++;
          $error("FAIL %s ACK observed %b expected %b", e.tag, LOAD_ACK, e.ack);
        end
        vectors++;
        assert (FRAME_START === e.fs) else begin
          miscompares++;
          $error("FAIL %s FRAME_START observed %b expected %b", e.tag, FRAME_START, e.fs);
        end
      end
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    LOAD_REQ  = 1'b0;
    DIGITS_IN = '0;
    DP_IN     = '0;
    EN_IN     = '0;

    // Reset, then idle with no request.
    idle(3, "reset");
    run(3);
    RST_N = 1'b1;
    idle(5, "idle_hold");
    run(5);

    // Full-frame load from IDLE.
    drive(DIG_A, 8'h00, 8'hFF);
    push_slot(0, DIG_A, 8'h00, 1'b1, 1'b1, "load_full");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    for (int s = 1; s < 8; s++) push_slot(s, DIG_A, 8'h00, 1'b0, 1'b0, "full_f1");
    run(70);
    for (int s = 0; s < 8; s++) push_slot(s, DIG_A, 8'h00, 1'b0, s == 0, "full_f2");
    run(80);

    // Sparse mask, loaded in the boundary cycle just observed.
    drive(DIG_SP, 8'h80, 8'h81);
    push_slot(0, DIG_SP, 8'h80, 1'b1, 1'b1, "sparse");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    push_slot(7, DIG_SP, 8'h80, 1'b0, 1'b0, "sparse_d7");
    push_slot(0, DIG_SP, 8'h80, 1'b0, 1'b1, "sparse_rep");
    push_slot(7, DIG_SP, 8'h80, 1'b0, 1'b0, "sparse_d7");
    run(30);

    // Mid-frame load: request raised in slot 3 waits for the frame boundary.
    drive(DIG_A, 8'h00, 8'hFF);
    push_slot(0, DIG_A, 8'h00, 1'b1, 1'b1, "mid_a");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    for (int s = 1; s < 8; s++) push_slot(s, DIG_A, 8'h00, 1'b0, 1'b0, "mid_old");
    run(23);
    drive(DIG_B, 8'h0F, 8'hFF);
    run(47);
    push_slot(0, DIG_B, 8'h0F, 1'b1, 1'b1, "mid_new");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    for (int s = 1; s < 8; s++) push_slot(s, DIG_B, 8'h0F, 1'b0, 1'b0, "mid_new");
    run(70);

    // Zero mask returns to IDLE; then a single-digit frame.
    drive(32'h0, 8'h00, 8'h00);
    push(8'hFF, 8'hFF, 1'b1, 1'b0, "zero_mask");
    run(1);
    LOAD_REQ = 1'b0;
    idle(4, "zero_idle");
    run(4);
    drive(DIG_F, 8'h00, 8'h01);
    push_slot(0, DIG_F, 8'h00, 1'b1, 1'b1, "single");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    push_slot(0, DIG_F, 8'h00, 1'b0, 1'b1, "single_rep");
    run(10);

    // Reset asserted while slot 5 is driven.
    drive(DIG_A, 8'h00, 8'hFF);
    push_slot(0, DIG_A, 8'h00, 1'b1, 1'b1, "pre_rst");
    run(1);
    LOAD_REQ = 1'b0;
    run(9);
    for (int s = 1; s < 5; s++) push_slot(s, DIG_A, 8'h00, 1'b0, 1'b0, "pre_rst");
    idle(2, "pre_rst_d5");
    repeat (3) push(8'hDF, seg(4'h5, 1'b0), 1'b0, 1'b0, "pre_rst_d5");
    run(45);
    RST_N = 1'b0;
    idle(1, "rst_mid");
    run(1);
    RST_N = 1'b1;
    idle(10, "post_rst");
    run(10);

    vectors++;
    assert (q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It owns the shared SSEG_AN/SSEG_CA pins and walks through the enabled digits one at a time, with a blanking gap between digits to prevent ghosting. Client logic delivers a complete frame of nibbles, decimal points and enables through a request/acknowledge handshake. New frames are applied only at frame boundaries, so the display never tears.

## Interface
- N_DIGITS, 8, number of digit positions.
- TICK_DIV, 100000, CLK cycles per digit slot; must exceed BLANK_CYC.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; at least 1.

- CLK  in  1  system clock; the block uses a single clock.
- RST_N  in  1  reset, synchronous and active-low.
- DIGITS_IN  in  4*N_DIGITS  hex nibble per digit; digit i is bits [4i+3:4i].
- DP_IN  in  N_DIGITS  decimal point per digit; 1 = lit.
- EN_IN  in  N_DIGITS  digit enable mask; 1 = scanned.
- LOAD_REQ  in  1  client holds this high, with the inputs stable, until LOAD_ACK.
- LOAD_ACK  out  1  one-cycle pulse; the inputs were captured.
- SSEG_CA  out  8  segment cathodes, active-low; bit 7 = DP, bits 6:0 = g..a.
- SSEG_AN  out  N_DIGITS  anodes, active-low, at most one bit low.
- FRAME_START  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- **Shadow registers:** digits, DP and enable mask. Reset values are all 0, so the block starts in IDLE.
- **States:**
  - IDLE: shadow enable mask is zero; the display is blank.
  - BLANK: first BLANK_CYC cycles of a slot; all anodes off.
  - DRIVE: remaining TICK_DIV-BLANK_CYC cycles of the slot; the current digit is driven.
- **Slot counter:** runs 0..TICK_DIV-1.
  - BLANK→DRIVE when the count reaches BLANK_CYC.
  - At count TICK_DIV-1, the slot ends and the index moves to the next enabled digit above the current one, wrapping to the lowest enabled digit.
  - Disabled digits take no time.
- **Frame boundary:** the end of a slot where the next index is ≤ the current index. With one enabled digit, every slot end is a frame boundary.
- **Loading:**
  - LOAD_REQ is sampled only in a frame-boundary cycle, or in any IDLE cycle.
  - When sampled high: the shadow registers capture the inputs, and LOAD_ACK pulses in the next cycle.
  - The new frame starts at the lowest enabled digit of the new mask.
  - If the new mask is zero, the next state is IDLE.
  - If LOAD_REQ is low at a boundary, the current frame repeats.
- **IDLE exit:** on a load with a nonzero mask. The next cycle is BLANK, count 0, with FRAME_START = 1.
- **Decoding (sseg_decode):** CA[6:0] per nibble, shown here as the full CA byte with DP off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - CA[7] = ~DP.
  - All 16 nibble values are decoded.
- **Blank output:** SSEG_AN all ones and SSEG_CA = 8'hFF, in both BLANK and IDLE.

## Timing
- **Reset:** SSEG_AN all ones, SSEG_CA 8'hFF, LOAD_ACK 0, FRAME_START 0, state IDLE, counter 0, shadow registers 0. All outputs are registered.
- **Reset mid-operation:** the next edge forces all reset values; a pending acknowledge is dropped.
- **Output timing:** outputs change on the same edge as the state and counter. Each slot is exactly TICK_DIV cycles: BLANK_CYC blank, then driven.
- **Load latency:**
  - Capture happens at the edge that ends the boundary cycle.
  - LOAD_ACK is high for the cycle after that edge, which is also the new frame's first cycle, with FRAME_START = 1.
- **Simultaneous events:** LOAD_REQ rising during the boundary cycle is accepted in that same cycle. A request that is still held after LOAD_ACK is treated as a new request at the next boundary.
- **Frame period:** popcount(mask) × TICK_DIV cycles.

## Structure
- **Package sseg_pkg:**
  - state enum {IDLE, BLANK, DRIVE}.
  - 16-entry segment constant table.
  - SEG_BLANK = 8'hFF.
- **Sub-module sseg_decode:** combinational, nibble + dp → 8-bit CA.
- **Controller:**
  - Next-enabled-index search: combinational, priority scan with wrap.
  - Prescaler/slot counter.
  - FSM.
  - Shadow registers.
  - Output registers.

## Test plan
Parameters for all scenarios: TICK_DIV=10, BLANK_CYC=2.
1. **Reset:** hold RST_N low 3 cycles → SSEG_AN=FF, SSEG_CA=FF, LOAD_ACK=0, FRAME_START=0; no change while idle without a request.
2. **Full-frame load from IDLE:** DIGITS_IN=0x76543210, EN_IN=FF, DP_IN=00 → LOAD_ACK pulses one cycle after the request is sampled.
   - Slot 0: AN=FF for 2 cycles, then AN=FE with CA=C0 for 8 cycles.
   - Slot 1: AN=FD with CA=F9.
   - FRAME_START every 80 cycles.
3. **Sparse mask:** EN=0x81 → slots alternate AN=FE and AN=7F, frame period 20 cycles. DP_IN[7]=1 with digit 7 = 8 → CA=0x00.
4. **Mid-frame load:** LOAD_REQ raised during slot 3 → no ACK until the frame boundary (end of slot 7). New data first appears in slot 0 of the next frame, and the old data is displayed unchanged until then.
5. **Zero mask:** load with EN=00 → blank outputs, state IDLE. A following load with EN=01 and digit 0 = F → ACK one cycle after the request, then AN=FE with CA=8E after 2 blank cycles.
6. **Reset mid-DRIVE:** RST_N low during slot 5 → next cycle AN=FF, CA=FF, no ACK; after release, the display stays blank until a new load.
